// File: rtl/mem_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer_if
// Purpose : data-memory handshake bus between the MEM-stage sequencer and the
//           data memory. A strobe (read or write) is held with constant
//           address/data/enables until the memory answers with dmem_resp.
// Signals : dmem_read        strobe: read access
//           dmem_write       strobe: write access
//           dmem_address     byte address of the access
//           dmem_wdata       write data (lane-steered for byte stores)
//           dmem_byte_enable one enable per byte lane
//           dmem_resp        access complete (read data valid this cycle)
//           dmem_rdata       read data
// Modports: master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  dmem_read;
  logic                  dmem_write;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [NB-1:0]         dmem_byte_enable;
  logic                  dmem_resp;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
// Purpose : MEM-stage sequencer. Turns one load/store request (LDR/STR/LDB/STB/
//           LDI/STI) into one or two handshaked data-memory accesses, generates
//           byte enables / lane steering, stalls the pipeline until the
//           sequence completes, and guards each access with a response
//           watchdog. Flushes squash loads and pointer fetches without
//           cutting an access short.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           req_valid/read/write     MEM-stage request and its direction
//           req_indirect, req_byte   pointer fetch first / byte-wide final access
//           req_addr, req_wdata      effective address, store data
//           flush                    squash of the MEM-stage instruction
//           stall                    freeze upstream stages (combinational)
//           rsp_valid, rsp_rdata     completion pulse and load result
//           err_timeout              sticky watchdog flag
//           dmem                     data-memory bus (master modport)
// Assumes DATA_WIDTH >= 16 (at least two byte lanes) and ADDR_WIDTH <= DATA_WIDTH.
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic                    req_indirect,
  input  logic                    req_byte,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    flush,
  output logic                    stall,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    err_timeout,
  mem_access_sequencer_if.master  dmem
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_read, r_write, r_indirect, r_byte, r_flushed;
  logic [ADDR_WIDTH-1:0] r_addr, r_ptr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CW-1:0]         r_cnt;
  logic                  r_rsp_valid, r_err_timeout;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_dmem_read, r_dmem_write;
  logic [ADDR_WIDTH-1:0] r_dmem_address;
  logic [DATA_WIDTH-1:0] r_dmem_wdata;
  logic [NB-1:0]         r_dmem_be;

  logic                  w_accept, w_issued, w_timeout, w_flush_now, w_dflush;
  logic [ADDR_WIDTH-1:0] w_base, w_d_addr;
  logic [NB-1:0]         w_d_be;
  logic [DATA_WIDTH-1:0] w_d_wdata, w_ld;

  function automatic logic [ADDR_WIDTH-1:0] f_word_addr(input logic [ADDR_WIDTH-1:0] a);
    f_word_addr = {a[ADDR_WIDTH-1:LB], {LB{1'b0}}};
  endfunction

  function automatic logic [NB-1:0] f_lane_en(input logic [ADDR_WIDTH-1:0] a, input logic is_byte);
    if (is_byte) f_lane_en = {{(NB-1){1'b0}}, 1'b1} << a[LB-1:0];
    else         f_lane_en = {NB{1'b1}};
  endfunction

  // Byte loads pick the addressed lane and zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] f_load(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [LB-1:0] lane,
                                                   input logic is_byte);
    logic [DATA_WIDTH-1:0] sh;
    sh = d >> {lane, 3'b000};
    f_load = is_byte ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} : d;
  endfunction

  assign w_accept    = (r_state == S_IDLE) & req_valid & (req_read | req_write) & ~flush;
  assign stall       = req_valid & (req_read | req_write) & (r_state != S_DONE);
  assign w_issued    = r_dmem_read | r_dmem_write;
  assign w_timeout   = (TIMEOUT != 0) && w_issued && !dmem.dmem_resp && (r_cnt == C_LAST);
  assign w_flush_now = r_flushed | flush;
  // Stores are never squashed once in DATA; only loads honour a flush there.
  assign w_dflush    = r_read & w_flush_now;

  // While leaving PTR the base is the pointer arriving on dmem_rdata, so the
  // data access is issued back to back with the pointer fetch.
  assign w_base    = (r_state == S_PTR) ? dmem.dmem_rdata[ADDR_WIDTH-1:0]
                                        : (r_indirect ? r_ptr : r_addr);
  assign w_d_addr  = r_byte ? w_base : f_word_addr(w_base);
  assign w_d_be    = f_lane_en(w_base, r_byte);
  assign w_d_wdata = r_write ? (r_byte ? {NB{r_wdata[7:0]}} : r_wdata) : {DATA_WIDTH{1'b0}};
  assign w_ld      = f_load(dmem.dmem_rdata, w_base[LB-1:0], r_byte);

  assign rsp_valid             = r_rsp_valid;
  assign rsp_rdata             = r_rsp_rdata;
  assign err_timeout           = r_err_timeout;
  assign dmem.dmem_read        = r_dmem_read;
  assign dmem.dmem_write       = r_dmem_write;
  assign dmem.dmem_address     = r_dmem_address;
  assign dmem.dmem_wdata       = r_dmem_wdata;
  assign dmem.dmem_byte_enable = r_dmem_be;

  // Sequencer FSM: capture, issue, wait/watchdog, complete; all outputs registered.
  // An access's first cycle in PTR/DATA registers the strobes; they then hold until resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_indirect     <= 1'b0;
      r_byte         <= 1'b0;
      r_flushed      <= 1'b0;
      r_addr         <= {ADDR_WIDTH{1'b0}};
      r_ptr          <= {ADDR_WIDTH{1'b0}};
      r_wdata        <= {DATA_WIDTH{1'b0}};
      r_cnt          <= {CW{1'b0}};
      r_rsp_valid    <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_rsp_rdata    <= {DATA_WIDTH{1'b0}};
      r_dmem_read    <= 1'b0;
      r_dmem_write   <= 1'b0;
      r_dmem_address <= {ADDR_WIDTH{1'b0}};
      r_dmem_wdata   <= {DATA_WIDTH{1'b0}};
      r_dmem_be      <= {NB{1'b0}};
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_flushed <= 1'b0;
          if (w_accept) begin
            r_read     <= req_read;
            r_write    <= req_write;
            r_indirect <= req_indirect;
            r_byte     <= req_byte;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= {CW{1'b0}};
            r_state    <= req_indirect ? S_PTR : S_DATA;
          end
        end
        S_PTR: begin
          if (!w_issued) begin
            if (w_flush_now) begin
              r_state <= S_IDLE;
            end else begin
              r_dmem_read    <= 1'b1;
              r_dmem_address <= f_word_addr(r_addr);
              r_dmem_be      <= {NB{1'b1}};
              r_dmem_wdata   <= {DATA_WIDTH{1'b0}};
              r_cnt          <= {CW{1'b0}};
            end
          end else if (dmem.dmem_resp) begin
            r_ptr <= dmem.dmem_rdata[ADDR_WIDTH-1:0];
            if (w_flush_now) begin
              r_dmem_read <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_dmem_read    <= r_read;
              r_dmem_write   <= r_write;
              r_dmem_address <= w_d_addr;
              r_dmem_be      <= w_d_be;
              r_dmem_wdata   <= w_d_wdata;
              r_cnt          <= {CW{1'b0}};
              r_state        <= S_DATA;
            end
          end else if (w_timeout) begin
            // A dead pointer fetch abandons the whole sequence.
            r_dmem_read   <= 1'b0;
            r_err_timeout <= 1'b1;
            if (w_flush_now) begin
              r_state <= S_IDLE;
            end else begin
              r_rsp_rdata <= {DATA_WIDTH{1'b0}};
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_flushed <= w_flush_now;
          end
        end
        S_DATA: begin
          if (!w_issued) begin
            if (w_dflush) begin
              r_state <= S_IDLE;
            end else begin
              r_dmem_read    <= r_read;
              r_dmem_write   <= r_write;
              r_dmem_address <= w_d_addr;
              r_dmem_be      <= w_d_be;
              r_dmem_wdata   <= w_d_wdata;
              r_cnt          <= {CW{1'b0}};
            end
          end else if (dmem.dmem_resp) begin
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            if (w_dflush) begin
              r_state <= S_IDLE;
            end else begin
              if (r_read) r_rsp_rdata <= w_ld;
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else if (w_timeout) begin
            r_dmem_read   <= 1'b0;
            r_dmem_write  <= 1'b0;
            r_err_timeout <= 1'b1;
            if (w_dflush) begin
              r_state <= S_IDLE;
            end else begin
              r_rsp_rdata <= {DATA_WIDTH{1'b0}};
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_flushed <= w_dflush;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
